vga_timing_gen: RTL



---
 rtl/vga_timing_gen.sv | 104 ++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/VESA raster timing generator.
// Runs from the system clock with an internal pixel-clock-enable divider.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int PIX_DIV  = 1,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          pix_tick,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          video_on,
  output logic          hblank,
  output logic          vblank,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;
  localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;

  logic tick;
  logic h_act;
  logic v_act;
  logic h_sy;
  logic v_sy;
  logic h_last;
  logic v_last;

  always_comb begin
    tick   = en && (div_cnt == DW'(PIX_DIV - 1));
    h_act  = h_cnt < CW'(H_ACTIVE);
    v_act  = v_cnt < CW'(V_ACTIVE);
    h_sy   = (h_cnt >= CW'(HS_BEG)) && (h_cnt < CW'(HS_END));
    v_sy   = (v_cnt >= CW'(VS_BEG)) && (v_cnt < CW'(VS_END));
    h_last = h_cnt == CW'(H_TOTAL - 1);
    v_last = v_cnt == CW'(V_TOTAL - 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt     <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      pix_tick    <= 1'b0;
      x           <= '0;
      y           <= '0;
      video_on    <= 1'b0;
      hblank      <= 1'b0;
      vblank      <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_tick    <= tick;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (en)
        div_cnt <= tick ? '0 : div_cnt + DW'(1);
      // Outputs show the current position; counters then advance.
      if (tick) begin
        x           <= h_act ? h_cnt : '0;
        y           <= v_act ? v_cnt : '0;
        video_on    <= h_act && v_act;
        hblank      <= !h_act;
        vblank      <= !v_act;
        hsync       <= h_sy ? HS_POL : ~HS_POL;
        vsync       <= v_sy ? VS_POL : ~VS_POL;
        line_start  <= h_cnt == '0;
        frame_start <= (h_cnt == '0) && (v_cnt == '0);
        if (h_last) begin
          h_cnt <= '0;
          v_cnt <= v_last ? '0 : v_cnt + CW'(1);
        end else begin
          h_cnt <= h_cnt + CW'(1);
        end
      end
    end
  end

endmodule
